// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter: grants one of N_REQ byte requesters to a shared UART tx. |
// | Define UART_ARB_RR_EN for round-robin, else fixed priority. Rev 1.0       |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_load,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     done,
  output logic                     err_timeout
);

  localparam int IDW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [7:0] C_CNT_LAST = 8'(BUSY_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic             load_q, load_d;
  logic [7:0]       data_q, data_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic             grant;

`ifdef UART_ARB_RR_EN
  logic [IDW-1:0] ptr_q;
  logic           hi_found, lo_found;
  logic [IDW-1:0] hi_idx, lo_idx;

  // Prefer the lowest valid index above the pointer, else wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) > ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDW'(N_REQ - 1);
    end else if (grant) begin
      ptr_q <= win_idx;
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end
`endif

  assign grant = (state_q == S_IDLE) && win_found && !tx_busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    load_d  = 1'b0;
    data_d  = data_q;
    gid_d   = gid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_LOAD;
          ready_d = N_REQ'(1) << win_idx;
          load_d  = 1'b1;
          data_d  = req_data[8*win_idx +: 8];
          gid_d   = win_idx;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A byte that never started is dropped, not retried.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == C_CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= '0;
      load_q   <= 1'b0;
      data_q   <= '0;
      gid_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      load_q   <= load_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign req_ready   = ready_q;
  assign tx_load     = load_q;
  assign tx_data     = data_q;
  assign grant_id    = gid_q;
  assign active      = active_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: table-driven grant checks with a scoreboard queue and
// hand-written corner-case sequences for uart_tx_arbiter.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic        tx_busy   = 1'b0;
  logic [3:0]  req_ready;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        active;
  logic        done;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          len;
    logic [1:0]  g;
    logic [7:0]  d;
  } vec_t;
  vec_t vt[6];

  uart_tx_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_load     (tx_load),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .done        (done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
    chk({tag, "_tx_load"}, {31'd0, tx_load}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
    chk({tag, "_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_timeout}, 32'd0);
  endtask

  // mode 0: requester drops all valids, 1: winner drops its own bit, 2: keep
  task automatic grant_check(input int mode);
    int   n;
    exp_t e;
    n = 0;
    tick();
    while (tx_load !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_latency", n, 0);
    e = sb_q.pop_front();
    chk("tx_load", {31'd0, tx_load}, 32'd1);
    chk("grant_id", {30'd0, grant_id}, {30'd0, e.g});
    chk("tx_data", {24'd0, tx_data}, {24'd0, e.d});
    chk("req_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << e.g});
    case (mode)
      0: req_valid = '0;
      1: req_valid[e.g] = 1'b0;
      default: ;
    endcase
  endtask

  // transmitter model: busy from the cycle after load for len cycles
  task automatic finish_frame(input int len);
    tick();
    tx_busy = 1'b1;
    chk("load_one_cycle", {31'd0, tx_load}, 32'd0);
    chk("ready_one_cycle", {28'd0, req_ready}, 32'd0);
    chk("active_in_frame", {31'd0, active}, 32'd1);
    repeat (len) tick();
    chk("no_early_done", {31'd0, done}, 32'd0);
    tx_busy = 1'b0;
    tick();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("inactive_at_done", {31'd0, active}, 32'd0);
  endtask

  task automatic do_frame(input logic [3:0] valid, input logic [31:0] data, input int len,
                          input logic [1:0] g, input logic [7:0] d, input int mode);
    exp_t e;
    req_valid = valid;
    req_data  = data;
    e.g = g;
    e.d = d;
    sb_q.push_back(e);
    grant_check(mode);
    finish_frame(len);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    tx_busy   = 1'b0;
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vt[0] = '{4'b0010, 32'h00005A00, 100, 2'd1, 8'h5A};
    vt[1] = '{4'b1001, 32'h33000011, 3, RR ? 2'd3 : 2'd0, RR ? 8'h33 : 8'h11};
    vt[2] = '{4'b0110, 32'h00422100, 1, 2'd1, 8'h21};
    vt[3] = '{4'b1111, 32'hA3A2A1A0, 4, RR ? 2'd2 : 2'd0, RR ? 8'hA2 : 8'hA0};
    vt[4] = '{4'b1000, 32'hC3000000, 2, 2'd3, 8'hC3};
    vt[5] = '{4'b0001, 32'h000000FF, 5, 2'd0, 8'hFF};

    repeat (3) tick();
    chk_reset_outputs("rst");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_frame(vt[i].valid, vt[i].data, vt[i].len, vt[i].g, vt[i].d, 0);
    end

    // Timeout: busy never rises after the load
    req_valid = 4'b0001;
    req_data  = 32'h00000077;
    e.g = 2'd0;
    e.d = 8'h77;
    sb_q.push_back(e);
    grant_check(0);
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 1) chk("to_active", {31'd0, active}, 32'd1);
      if (t < 9) begin
        chk("to_no_early_err", {31'd0, err_timeout}, 32'd0);
      end else begin
        chk("to_err_pulse", {31'd0, err_timeout}, 32'd1);
        chk("to_no_done", {31'd0, done}, 32'd0);
        chk("to_idle", {31'd0, active}, 32'd0);
      end
    end
    tick();
    chk("to_err_one_cycle", {31'd0, err_timeout}, 32'd0);
    chk("to_no_done_after", {31'd0, done}, 32'd0);

    // Busy in IDLE holds off the grant
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h0000003C;
    e.g = 2'd0;
    e.d = 8'h3C;
    sb_q.push_back(e);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("busy_blocks_load", {31'd0, tx_load}, 32'd0);
    end
    tx_busy = 1'b0;
    grant_check(0);
    finish_frame(2);

    // Reset while in WAIT_DONE
    req_valid = 4'b0100;
    req_data  = 32'h00990000;
    e.g = 2'd2;
    e.d = 8'h99;
    sb_q.push_back(e);
    grant_check(0);
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    chk("mid_active", {31'd0, active}, 32'd1);
    rst     = 1'b1;
    tx_busy = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    do_frame(4'b1111, 32'h44332211, 3, 2'd0, 8'h11, 0);

    // Contention: each requester clears only its own bit after acceptance
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_frame(4'(4'b1111 << i), 32'h13121110, 3, 2'(i), 8'(8'h10 + i), 1);
    end

    // Requesters 1 and 3 held valid for three frames
    do_reset();
    for (int f = 0; f < 3; f++) begin
      do_frame(4'b1010, 32'hB300B100, 3, (RR && f == 1) ? 2'd3 : 2'd1,
               (RR && f == 1) ? 8'hB3 : 8'hB1, 2);
    end
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter among `N_REQ` byte requesters. It selects one pending requester and hands its byte to the transmitter with a one-cycle load strobe. It then follows the transmitter's busy flag until the frame completes and returns to arbitration. It sits between client blocks (command responders, status reporters, debug taps) and the `transmitter` datapath. It owns the transmitter's `load` and `data_in` inputs and observes its `busy` output.

## Interface
- `N_REQ`, default 4: number of requesters; range 2..8.
- `BUSY_TIMEOUT`, default 8: cycles allowed after `tx_load` for `tx_busy` to rise; range 2..255.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `req_valid` input, `N_REQ` bits: bit i means requester i has a byte pending.
- `req_data` input, `8*N_REQ` bits: byte of requester i in bits [8i+7:8i].
- `req_ready` output, `N_REQ` bits: one-cycle acknowledge, one-hot.
- `tx_load` output, 1 bit: load strobe to the transmitter.
- `tx_data` output, 8 bits: byte to the transmitter, held stable from load until the next grant.
- `tx_busy` input, 1 bit: transmitter busy flag.
- `grant_id` output, `$clog2(N_REQ)` bits: index of the current or last granted requester.
- `active` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse when a frame completes.
- `err_timeout` output, 1 bit: one-cycle pulse when `tx_busy` fails to rise in time.

## Operation
- Reset values: state IDLE. `req_ready`=0, `tx_load`=0, `tx_data`=0, `grant_id`=0, `active`=0, `done`=0, `err_timeout`=0. Round-robin pointer = `N_REQ`-1, so index 0 wins first.
- All outputs are registered.
- **IDLE**: if any `req_valid` bit is set and `tx_busy`=0, select winner g.
  - Latch `req_data[g]` into `tx_data` and set `grant_id`=g.
  - Pulse `req_ready[g]` and `tx_load` for one cycle.
  - Go to LOAD.
  - If `tx_busy`=1 in IDLE, issue no grant.
- **LOAD**: one cycle with `tx_load`=1. Clear the timeout counter. Go to WAIT_BUSY.
- **WAIT_BUSY**: if `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches `BUSY_TIMEOUT`: pulse `err_timeout` and go to IDLE. The granted byte counts as consumed and is not retried.
- **WAIT_DONE**: when `tx_busy`=0, pulse `done` and go to IDLE.
- A requester treats `req_ready[i]`=1 as acceptance of its byte. It must update `req_data`/`req_valid` within the next 2 cycles, before the arbiter next samples.
- `req_valid` deasserting after grant has no effect on the frame in progress.
- Reset asserted in any state returns to IDLE on the next edge and drops `tx_load` immediately. The transmitter is reset by the same `rst`.

## Timing
- Request to `tx_load` latency: `req_valid` sampled high at edge k gives `tx_load`=1 and `req_ready`=1 during cycle k+1.
- `tx_busy` is expected high from cycle k+2, because the transmitter registers busy one cycle after load.
- Minimum grant-to-grant spacing: one full frame plus 2 cycles (the WAIT_DONE→IDLE cycle, then the IDLE decision cycle).
- `done` is high during the cycle after `tx_busy` is sampled low. `active` is 0 in that same cycle.
- The timeout fires when `tx_busy` is still 0 at the `BUSY_TIMEOUT`-th WAIT_BUSY cycle.
- Simultaneous requests are resolved in the IDLE cycle only. Requests arriving during a frame wait.

## Configuration
- `UART_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at pointer+1, modulo `N_REQ`.
  - The pointer updates to g on each grant, including grants that later time out.
- `UART_ARB_RR_EN` undefined: fixed priority, lowest index wins. The pointer logic is removed. `grant_id` behaves identically otherwise.

## Test plan
- **Single requester:** `req_valid`=4'b0010, byte 0x5A; model busy rising 1 cycle after load and falling 100 cycles later. Expect:
  - `req_ready`=4'b0010 and `tx_load`=1 for exactly one cycle, `tx_data`=0x5A, `grant_id`=1;
  - `done` one cycle after busy falls.
- **RR contention (macro defined):** all four valid, bytes 0x10..0x13, each requester clears after its ready. Expect grant order 0,1,2,3 and `tx_data` sequence 0x10,0x11,0x12,0x13.
- **Fixed priority (macro undefined):** requesters 1 and 3 valid continuously, 3 frames. Expect `grant_id`=1 all three times and requester 3 never acknowledged.
- **Timeout:** `tx_busy` held 0 after load, `BUSY_TIMEOUT`=8. Expect:
  - `err_timeout` pulse 8 cycles after leaving LOAD;
  - return to IDLE;
  - no `done`.
- **Busy blocks grant:** `tx_busy`=1 in IDLE with `req_valid`=4'b0001. Expect no `tx_load` until `tx_busy`=0, then a grant on the next cycle.
- **Reset mid-frame:** assert `rst` in WAIT_DONE. Expect all outputs at reset values next cycle and the next grant going to index 0.
